// File: rtl/rll_pkg.sv
// Shared definitions for the rll16 key-delivery front end: CRC-4 constants,
// the loader state encoding and the serial CRC-4 step used by RTL and benches.
package rll_pkg;

    localparam int             CRC_WIDTH = 4;
    localparam logic [3:0]     CRC4_POLY = 4'b0011;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SHIFT_KEY = 3'd1,
        ST_SHIFT_CRC = 3'd2,
        ST_CHECK     = 3'd3,
        ST_LOCKOUT   = 3'd4
    } loader_state_t;

    // One serial step of x^4+x+1: feedback is the incoming bit XOR the MSB.
    function automatic logic [CRC_WIDTH-1:0] crc4_step(
        input logic [CRC_WIDTH-1:0] crc,
        input logic                 b
    );
        logic fb;
        fb = b ^ crc[CRC_WIDTH-1];
        return {crc[CRC_WIDTH-2:0], 1'b0} ^ (fb ? CRC4_POLY : 4'b0000);
    endfunction

endpackage

// File: rtl/rll_crc4.sv
// Serial CRC-4 accumulator (x^4+x+1, init 0, no final XOR) with a
// synchronous clear and a per-bit enable.
module rll_crc4
    import rll_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 en,
    input  logic                 din,
    output logic [CRC_WIDTH-1:0] crc
);

    logic [CRC_WIDTH-1:0] crc_r;

    // Accumulate one bit per enabled cycle; clear restarts a frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            crc_r <= 4'b0000;
        end else if (clr) begin
            crc_r <= 4'b0000;
        end else if (en) begin
            crc_r <= crc4_step(crc_r, din);
        end else begin
            crc_r <= crc_r;
        end
    end

    assign crc = crc_r;

endmodule

// File: rtl/rll_key_loader.sv
// Serial key-frame receiver for the rll16 locked netlist: shifts in
// KEY_WIDTH key bits plus a 4-bit CRC, verifies it, and atomically commits
// the key. MAX_FAIL consecutive CRC failures force a terminal lockout.
module rll_key_loader
    import rll_pkg::*;
#(
    parameter int KEY_WIDTH = 16,
    parameter int MAX_FAIL  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 s_bit,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic [KEY_WIDTH-1:0] key_out,
    output logic                 key_valid,
    output logic                 done,
    output logic                 err,
    output logic                 lockout,
    output logic                 busy
);

    localparam int CNT_W  = $clog2(KEY_WIDTH + 1);
    localparam int FAIL_W = $clog2(MAX_FAIL + 1);

    loader_state_t        state_r;
    loader_state_t        state_nxt_s;
    logic [KEY_WIDTH-1:0] shift_r;
    logic [CRC_WIDTH-1:0] rx_crc_r;
    logic [CNT_W-1:0]     bit_cnt_r;
    logic [FAIL_W-1:0]    fail_cnt_r;
    logic [FAIL_W-1:0]    fail_inc_s;
    logic [KEY_WIDTH-1:0] key_out_r;
    logic                 key_valid_r;
    logic                 done_r;
    logic                 err_r;
    logic                 lockout_r;
    logic                 s_ready_r;
    logic                 busy_r;
    logic                 xfer_s;
    logic                 last_key_s;
    logic                 last_crc_s;
    logic                 crc_clr_s;
    logic                 crc_en_s;
    logic                 crc_match_s;
    logic [CRC_WIDTH-1:0] crc_s;

    rll_crc4 u_crc (
        .clk (clk),
        .rst (rst),
        .clr (crc_clr_s),
        .en  (crc_en_s),
        .din (s_bit),
        .crc (crc_s)
    );

    // Handshake decode and next-state selection; abort beats a bit transfer.
    always_comb begin
        xfer_s      = s_ready_r && s_valid && !abort;
        last_key_s  = (bit_cnt_r == CNT_W'(KEY_WIDTH - 1));
        last_crc_s  = (bit_cnt_r == CNT_W'(CRC_WIDTH - 1));
        crc_clr_s   = (state_r == ST_IDLE) && start;
        crc_en_s    = xfer_s && (state_r == ST_SHIFT_KEY);
        crc_match_s = (crc_s == rx_crc_r);
        fail_inc_s  = fail_cnt_r + FAIL_W'(1);
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_SHIFT_KEY;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT_KEY: begin
                if (abort) begin
                    state_nxt_s = ST_IDLE;
                end else if (xfer_s && last_key_s) begin
                    state_nxt_s = ST_SHIFT_CRC;
                end else begin
                    state_nxt_s = ST_SHIFT_KEY;
                end
            end
            ST_SHIFT_CRC: begin
                if (abort) begin
                    state_nxt_s = ST_IDLE;
                end else if (xfer_s && last_crc_s) begin
                    state_nxt_s = ST_CHECK;
                end else begin
                    state_nxt_s = ST_SHIFT_CRC;
                end
            end
            ST_CHECK: begin
                if (!crc_match_s && (fail_inc_s == FAIL_W'(MAX_FAIL))) begin
                    state_nxt_s = ST_LOCKOUT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOCKOUT: begin
                state_nxt_s = ST_LOCKOUT;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Loader FSM with frame datapath, fail counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            shift_r     <= '0;
            rx_crc_r    <= 4'b0000;
            bit_cnt_r   <= '0;
            fail_cnt_r  <= '0;
            key_out_r   <= '0;
            key_valid_r <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            lockout_r   <= 1'b0;
            s_ready_r   <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            s_ready_r <= (state_nxt_s == ST_SHIFT_KEY) || (state_nxt_s == ST_SHIFT_CRC);
            busy_r    <= (state_nxt_s != ST_IDLE) && (state_nxt_s != ST_LOCKOUT);
            done_r    <= 1'b0;
            err_r     <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        bit_cnt_r <= '0;
                        shift_r   <= '0;
                        rx_crc_r  <= 4'b0000;
                    end else begin
                        bit_cnt_r <= bit_cnt_r;
                    end
                end
                ST_SHIFT_KEY: begin
                    if (xfer_s) begin
                        shift_r <= {shift_r[KEY_WIDTH-2:0], s_bit};
                        if (last_key_s) begin
                            bit_cnt_r <= '0;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                        end
                    end else begin
                        bit_cnt_r <= bit_cnt_r;
                    end
                end
                ST_SHIFT_CRC: begin
                    if (xfer_s) begin
                        rx_crc_r  <= {rx_crc_r[CRC_WIDTH-2:0], s_bit};
                        bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                    end else begin
                        bit_cnt_r <= bit_cnt_r;
                    end
                end
                ST_CHECK: begin
                    if (crc_match_s) begin
                        key_out_r   <= shift_r;
                        key_valid_r <= 1'b1;
                        done_r      <= 1'b1;
                        fail_cnt_r  <= '0;
                    end else begin
                        err_r      <= 1'b1;
                        fail_cnt_r <= fail_inc_s;
                        if (fail_inc_s == FAIL_W'(MAX_FAIL)) begin
                            key_out_r   <= '0;
                            key_valid_r <= 1'b0;
                            lockout_r   <= 1'b1;
                        end else begin
                            key_valid_r <= key_valid_r;
                        end
                    end
                end
                ST_LOCKOUT: begin
                    lockout_r <= 1'b1;
                end
                default: begin
                    bit_cnt_r <= '0;
                end
            endcase
        end
    end

    assign s_ready   = s_ready_r;
    assign key_out   = key_out_r;
    assign key_valid = key_valid_r;
    assign done      = done_r;
    assign err       = err_r;
    assign lockout   = lockout_r;
    assign busy      = busy_r;

endmodule
